// File: rtl/uart_conduit_rx_pkg.sv
// Shared types and constants for the UART conduit receiver.
// The PARITY state only exists when UART_RX_PARITY_EN is defined.
package uart_conduit_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        ST_WAIT_IDLE,
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } rx_state_e;

    // Clocks per oversample tick, truncated.
    function automatic int calc_div(input int clk_hz, input int baud, input int os);
        return clk_hz / (baud * os);
    endfunction

endpackage

// File: rtl/uart_conduit_rx_if.sv
// Received-byte stream: first-word-fall-through data with valid/ready.
interface uart_conduit_rx_if;
    logic [uart_conduit_pkg::DATA_W-1:0] m_data;
    logic                                m_valid;
    logic                                m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/uart_conduit_rx_fifo.sv
// Synchronous FWFT byte FIFO; head reads 0 while empty.
module uart_rx_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q, rd_q;
    logic         wr_en, rd_en;

    // Extra MSB on the pointers separates full from empty.
    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign head  = empty ? '0 : mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (wr_en) wr_q <= wr_q + 1'b1;
            if (rd_en) rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_conduit_rx.sv
// Oversampling UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) feeding a
// FWFT byte FIFO; pulses frame/parity/overrun errors.
module uart_conduit_rx
    import uart_conduit_pkg::*;
#(
    parameter int CLK_HZ     = 125000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic               clk_125_clk,
    input  logic               rst_125_reset_n,
    input  logic               rxd,
    uart_conduit_rx_if.master  m,
    output logic               frame_err,
    output logic               parity_err,
    output logic               overrun,
    output logic               busy
);
    localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int TW  = $clog2(DIV);
    localparam int PW  = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [PW-1:0] HALF_LAST = PW'(OVERSAMPLE / 2 - 1);
    localparam logic [PW-1:0] FULL_LAST = PW'(OVERSAMPLE - 1);

    rx_state_e          state_q, state_d;
    logic [1:0]         sync_q;
    logic               prev_q;
    logic               rx_s;
    logic [TW-1:0]      tick_q;
    logic [PW-1:0]      phase_q;
    logic [2:0]         bit_cnt_q;
    logic [DATA_W-1:0]  shreg_q;
    logic               tick, phase_last, sample, start_det;
    logic               push, pop, full, empty;
    logic               ferr_d, par_bad;
    logic               frame_err_q, overrun_q, busy_q;

    assign rx_s      = sync_q[1];
    assign start_det = (state_q == ST_IDLE) && prev_q && !rx_s;

    always_ff @(posedge clk_125_clk or negedge rst_125_reset_n) begin
        if (!rst_125_reset_n) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], rxd};
            prev_q <= rx_s;
        end
    end

    // START waits half a bit to land mid-bit; later samples are a full bit apart.
    assign tick       = (tick_q == TICK_LAST);
    assign phase_last = (state_q == ST_START) ? (phase_q == HALF_LAST) : (phase_q == FULL_LAST);
    assign sample     = tick && phase_last;

    always_ff @(posedge clk_125_clk or negedge rst_125_reset_n) begin
        if (!rst_125_reset_n) begin
            tick_q  <= '0;
            phase_q <= '0;
        end else if (start_det) begin
            tick_q  <= '0;
            phase_q <= '0;
        end else begin
            tick_q <= tick ? '0 : tick_q + TW'(1);
            if (tick) phase_q <= phase_last ? '0 : phase_q + PW'(1);
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_q;
    logic perr_d;
    logic parity_err_q;
    assign par_bad = (par_q != ^shreg_q);
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge clk_125_clk or negedge rst_125_reset_n) begin
        if (!rst_125_reset_n) begin
            bit_cnt_q <= '0;
            shreg_q   <= '0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else if (sample) begin
            if (state_q == ST_START) bit_cnt_q <= '0;
            if (state_q == ST_DATA) begin
                shreg_q   <= {rx_s, shreg_q[DATA_W-1:1]};
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end
`ifdef UART_RX_PARITY_EN
            if (state_q == ST_PARITY) par_q <= rx_s;
`endif
        end
    end

    always_ff @(posedge clk_125_clk or negedge rst_125_reset_n) begin
        if (!rst_125_reset_n) state_q <= ST_WAIT_IDLE;
        else                  state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d  = 1'b0;
`endif
        case (state_q)
            ST_WAIT_IDLE: if (rx_s) state_d = ST_IDLE;
            ST_IDLE:      if (start_det) state_d = ST_START;
            ST_START:     if (sample) state_d = rx_s ? ST_IDLE : ST_DATA;
            ST_DATA: begin
                if (sample && bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY:    if (sample) state_d = ST_STOP;
`endif
            ST_STOP: begin
                if (sample) begin
                    if (rx_s) begin
                        state_d = ST_IDLE;
                        push    = !par_bad;
`ifdef UART_RX_PARITY_EN
                        perr_d  = par_bad;
`endif
                    end else begin
                        // Line held low: wait for idle so a break yields one error.
                        state_d = ST_WAIT_IDLE;
                        ferr_d  = 1'b1;
                    end
                end
            end
            default:      state_d = ST_WAIT_IDLE;
        endcase
    end

    assign pop = !empty && m.m_ready;

    uart_rx_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_125_clk),
        .rst_n (rst_125_reset_n),
        .push  (push),
        .pop   (pop),
        .din   (shreg_q),
        .full  (full),
        .empty (empty),
        .head  (m.m_data)
    );

    assign m.m_valid = !empty;

    always_ff @(posedge clk_125_clk or negedge rst_125_reset_n) begin
        if (!rst_125_reset_n) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            frame_err_q <= ferr_d;
            overrun_q   <= push && full && !pop;
            busy_q      <= (state_d != ST_IDLE);
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk_125_clk or negedge rst_125_reset_n) begin
        if (!rst_125_reset_n) parity_err_q <= 1'b0;
        else                  parity_err_q <= perr_d;
    end
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_conduit_rx.sv
// Directed/random bench for uart_conduit_rx; builds with or without UART_RX_PARITY_EN.
module tb_uart_conduit_rx;
    localparam int CLK_HZ = 125000000;
    localparam int BAUD   = 1953125;
    localparam int OS     = 16;
    localparam int DEPTH  = 16;
    localparam int DIV    = CLK_HZ / (BAUD * OS);
    localparam int BIT    = DIV * OS;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS  = 11;
`else
    localparam int NBITS  = 10;
`endif
    // Centre of the stop bit, in clocks after the start edge.
    localparam int STOP_CTR = BIT * (NBITS - 1) + BIT / 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rxd = 1'b1;
    logic frame_err, parity_err, overrun, busy;
`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    uart_conduit_rx_if bus ();

    uart_conduit_rx #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_125_clk     (clk),
        .rst_125_reset_n (rst_n),
        .rxd             (rxd),
        .m               (bus),
        .frame_err       (frame_err),
        .parity_err      (parity_err),
        .overrun         (overrun),
        .busy            (busy)
    );

    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Monitor: collects accepted bytes, counts flag pulses, notes m_valid rises.
    logic [7:0] rx_q[$];
    int   fe_cnt = 0, pe_cnt = 0, ov_cnt = 0, rise_cyc = -1;
    logic vprev = 1'b0;
    always @(negedge clk) begin
        if (bus.m_valid && bus.m_ready) rx_q.push_back(bus.m_data);
        if (frame_err)  fe_cnt++;
        if (parity_err) pe_cnt++;
        if (overrun)    ov_cnt++;
        if (bus.m_valid && !vprev) rise_cyc = cyc;
        vprev = bus.m_valid;
    end

    int n_vec = 0, n_err = 0, rd_idx = 0, start_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v);
        start_cyc = cyc;
        rxd = 1'b0;
        tick(BIT);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(BIT);
        end
`ifdef UART_RX_PARITY_EN
        rxd = (^b) ^ par_flip;
        tick(BIT);
`endif
        rxd = stop_v;
        tick(BIT);
        rxd = 1'b1;
    endtask

    task automatic expect_rx(input string tag, input logic [7:0] eq[$]);
        int n = eq.size();
        int k = 0;
        while (rx_q.size() < rd_idx + n && k < 8 * BIT) begin
            tick(1);
            k++;
        end
        tick(BIT / 2);
        chk({tag, "_count"}, rx_q.size() - rd_idx, n);
        for (int i = 0; i < n && rd_idx + i < rx_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), rx_q[rd_idx + i], eq[i]);
        rd_idx = rx_q.size();
    endtask

    initial begin
        logic [7:0] eq[$];
        logic [7:0] b;
        int lat, fe0, pe0, ov0;

        bus.m_ready = 1'b0;
        tick(5);
        chk("rst_valid", bus.m_valid, 0);
        chk("rst_data", bus.m_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flags", {frame_err, parity_err, overrun}, 0);
        rst_n = 1'b1;
        tick(10);
        chk("idle_busy", busy, 0);

        // Single byte, latency of m_valid against stop-bit centre
        fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
        send_frame(8'hA5, 1'b1);
        lat = rise_cyc - start_cyc;
        chk("a5_latency_window", (lat >= STOP_CTR - DIV && lat <= STOP_CTR + DIV + 4), 1);
        chk("a5_valid", bus.m_valid, 1);
        chk("a5_data", bus.m_data, 8'hA5);
        chk("a5_flags", (fe_cnt - fe0) + (pe_cnt - pe0) + (ov_cnt - ov0), 0);
        bus.m_ready = 1'b1;
        eq = '{8'hA5};
        expect_rx("a5", eq);

        // Three queued bytes, read out in order
        bus.m_ready = 1'b0;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        tick(20);
        chk("q3_head_stable", bus.m_data, 8'h00);
        chk("q3_valid", bus.m_valid, 1);
        bus.m_ready = 1'b1;
        eq = '{8'h00, 8'hFF, 8'h3C};
        expect_rx("q3", eq);

        // Random back-to-back bytes with consumer ready
        eq.delete();
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            eq.push_back(b);
            send_frame(b, 1'b1);
        end
        expect_rx("rand", eq);

        // 17 bytes into a 16-deep FIFO: last one is dropped
        bus.m_ready = 1'b0;
        ov0 = ov_cnt;
        eq.delete();
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = 8'($urandom);
            if (i < DEPTH) eq.push_back(b);
            send_frame(b, 1'b1);
        end
        tick(10);
        chk("ovf_pulse", ov_cnt - ov0, 1);
        chk("ovf_head", bus.m_data, eq[0]);
        bus.m_ready = 1'b1;
        expect_rx("ovf", eq);

        // Full FIFO, pop coinciding with the 17th push: byte accepted
        bus.m_ready = 1'b0;
        ov0 = ov_cnt;
        eq.delete();
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom);
            eq.push_back(b);
            send_frame(b, 1'b1);
        end
        b = 8'($urandom);
        eq.push_back(b);
        fork
            send_frame(b, 1'b1);
            begin
                tick(lat - 1);
                bus.m_ready = 1'b1;
                tick(1);
                bus.m_ready = 1'b0;
            end
        join
        tick(10);
        chk("samecyc_no_ovf", ov_cnt - ov0, 0);
        chk("samecyc_one_pop", rx_q.size() - rd_idx, 1);
        bus.m_ready = 1'b1;
        expect_rx("samecyc", eq);

        // Short low glitch in idle: false start
        fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
        rxd = 1'b0;
        tick(18);
        rxd = 1'b1;
        tick(4);
        chk("glitch_busy", busy, 1);
        tick(BIT);
        chk("glitch_idle", busy, 0);
        chk("glitch_flags", (fe_cnt - fe0) + (pe_cnt - pe0) + (ov_cnt - ov0), 0);
        chk("glitch_no_push", rx_q.size() - rd_idx, 0);

        // Stop bit low then 20-bit break: one frame error only
        fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
        send_frame(8'h55, 1'b0);
        rxd = 1'b0;
        tick(20 * BIT);
        chk("break_busy", busy, 1);
        rxd = 1'b1;
        tick(2 * BIT);
        chk("break_fe_once", fe_cnt - fe0, 1);
        chk("break_other_flags", (pe_cnt - pe0) + (ov_cnt - ov0), 0);
        chk("break_idle", busy, 0);
        chk("break_no_push", rx_q.size() - rd_idx, 0);
        b = 8'($urandom);
        eq = '{b};
        send_frame(b, 1'b1);
        expect_rx("post_break", eq);

`ifdef UART_RX_PARITY_EN
        fe0 = fe_cnt; pe0 = pe_cnt;
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        par_flip = 1'b0;
        tick(BIT);
        chk("par_bad_pulse", pe_cnt - pe0, 1);
        chk("par_bad_no_fe", fe_cnt - fe0, 0);
        chk("par_bad_no_push", rx_q.size() - rd_idx, 0);
        eq = '{8'h07};
        send_frame(8'h07, 1'b1);
        expect_rx("par_good", eq);
`else
        chk("no_parity_err", pe_cnt, 0);
`endif

        // Reset in the middle of a frame with a byte buffered
        bus.m_ready = 1'b0;
        send_frame(8'($urandom), 1'b1);
        tick(4);
        chk("mid_buffered", bus.m_valid, 1);
        rxd = 1'b0;
        tick(3 * BIT);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", bus.m_valid, 0);
        chk("mid_rst_data", bus.m_data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_flags", {frame_err, parity_err, overrun}, 0);
        rxd = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(BIT);
        chk("mid_rst_idle", busy, 0);
        bus.m_ready = 1'b1;
        b = 8'($urandom);
        eq = '{b};
        send_frame(b, 1'b1);
        expect_rx("post_rst", eq);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/uart_conduit_rx.md
# uart_conduit_rx

Byte-oriented UART receiver that deserializes an asynchronous 8N1 serial line (8E1 when parity is compiled in) into a first-word-fall-through byte stream with valid/ready handshake. It is the receiving peer for the system UART conduit: it decodes the `uart_conduit_txd` line, either on the bench or in a loopback/debug design. It runs in the 125 MHz domain, oversamples the line and buffers received bytes in a small FIFO.

## Interface
Parameters:
- `CLK_HZ`, default 125000000: clock frequency.
- `BAUD`, default 115200: line rate.
- `OVERSAMPLE`, default 16: ticks per bit. Must be even and ≥ 8.
- `FIFO_DEPTH`, default 16: byte buffer depth. Must be a power of 2 and ≥ 2.

Ports:
- `clk_125_clk` in 1: clock.
- `rst_125_reset_n` in 1: asynchronous reset, active-low.
- `rxd` in 1: serial line, idle high, asynchronous to the clock.
- `m_data` out 8: head byte of the FIFO.
- `m_valid` out 1: FIFO not empty.
- `m_ready` in 1: consumer accepts `m_data` this cycle.
- `frame_err` out 1: one-cycle pulse when the stop bit is sampled low.
- `parity_err` out 1: one-cycle pulse on parity mismatch. Tied 0 without the macro.
- `overrun` out 1: one-cycle pulse when a good byte is dropped because the FIFO is full.
- `busy` out 1: FSM not in IDLE.

## Operation
- `rxd` passes through a 2-flop synchronizer. Both flops reset to 1.
- Tick generator:
  - `DIV = CLK_HZ / (BAUD*OVERSAMPLE)`, integer truncation, must be ≥ 2. Default is 67.
  - Tick counter width is `$clog2(DIV)`.
  - Tick counter and bit-phase counter clear on start detect.
- FSM states: WAIT_IDLE, IDLE, START, DATA, PARITY (macro only), STOP.
  - Reset → WAIT_IDLE.
  - WAIT_IDLE → IDLE when the synced line is high.
  - IDLE → START on a synced falling edge (previous sample 1, current sample 0).
  - START: samples at tick `OVERSAMPLE/2`. If the line is high it is a false start → IDLE, no flags. If low → DATA.
  - DATA: samples 8 bits, LSB first, each `OVERSAMPLE` ticks after the previous sample. After bit 7 → PARITY, or STOP without the macro.
  - PARITY: samples one bit, then → STOP.
  - STOP: samples one bit.
    - High: push the byte unless parity failed; → IDLE.
    - Low: pulse `frame_err`, discard the byte, → WAIT_IDLE. A break condition therefore produces exactly one `frame_err`.
- FIFO:
  - Push is accepted if not full, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and `overrun` pulses.
  - Pop occurs when `m_valid && m_ready`.
  - Pointer width is `$clog2(FIFO_DEPTH)+1`; the wrap bit distinguishes full from empty.
- Error flags are never asserted together for one frame. Precedence: `frame_err` > `parity_err` > `overrun`.

## Timing
- Reset values: `m_valid` 0, `m_data` 0, `frame_err`/`parity_err`/`overrun` 0, `busy` 0.
- Start detect occurs 2–3 clocks after the `rxd` falling edge (synchronizer delay).
- Samples are taken at bit centre ± one tick. At defaults one bit is `16*67 = 1072` clocks.
- A pushed byte appears on `m_valid`/`m_data` 1 clock after the stop-sample cycle.
- `m_data` is stable while `m_valid && !m_ready`.
- Reset mid-frame returns the block to WAIT_IDLE with an empty FIFO. The remainder of the frame is not decoded until the line is next seen high; after that, a later low bit within the aborted frame can be detected as a new start.
- Back-to-back frames with a full-length stop bit are received without loss.

## Configuration
- `UART_RX_PARITY_EN`:
  - Defined: frame is 8E1. The PARITY state exists, and a mismatch pulses `parity_err` and discards the byte.
  - Undefined: frame is 8N1, the PARITY state is absent and `parity_err` is constant 0.

## Structure
- Package `uart_conduit_pkg` holds:
  - the FSM state enum;
  - the `DIV` computation function;
  - the data width constant (8).
- One sub-module, `uart_rx_fifo`: synchronous FWFT FIFO, parameterized by width and depth, exposing `push`, `pop`, `full`, `empty`, `head`.
- The FSM, synchronizer and tick generator stay in the top module.

## Test plan
- Send 0xA5 at 115200 with the macro undefined → `m_data` = 0xA5, `m_valid` rises 1 clock after the stop sample, no error flags.
- Send 0x00, 0xFF, 0x3C back-to-back with `m_ready` held 0 → three bytes are queued, then read out in order 0x00, 0xFF, 0x3C when `m_ready` goes to 1.
- Send 17 bytes with `m_ready` = 0 → the first 16 are retained and the 17th pulses `overrun`. With a pop in the same cycle as the 17th push, the byte is instead accepted.
- Apply a 300-clock low glitch in idle → START rejects it as a false start, no push, no flags, `busy` returns to 0.
- Send 0x55 with the stop bit forced low, then hold `rxd` low for 20 bit times → exactly one `frame_err`, no push, and the block resumes on the next valid frame.
- With `UART_RX_PARITY_EN`, send 0x07 with odd parity → `parity_err` pulses and there is no push. Send 0x07 with correct parity → 0x07 is delivered. Assert reset mid-frame → all outputs return to reset values.
